// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if -- bundle of the fetch stage's non-clock signals.
//   DE redirect inputs : IF_Stall, PCSrc, JSrc, J_target_DE, JR_target_DE,
//                        Br_target_DE
//   Instruction SRAM   : inst_sram_en, inst_sram_wen, inst_sram_addr (out),
//                        inst_sram_rdata (in, one cycle after the address)
//   IF/DE pipeline reg : Inst_IF_DE, PC_IF_DE, PC_add_4_IF_DE, Valid_IF_DE
// The master modport is the fetch stage; slave is the surrounding core/SRAM.
// ----------------------------------------------------------------------------
interface fetch_if;
    logic        IF_Stall;
    logic [1:0]  PCSrc;
    logic        JSrc;
    logic [31:0] J_target_DE;
    logic [31:0] JR_target_DE;
    logic [31:0] Br_target_DE;

    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    logic [31:0] Inst_IF_DE;
    logic [31:0] PC_IF_DE;
    logic [31:0] PC_add_4_IF_DE;
    logic        Valid_IF_DE;

    modport master (
        input  IF_Stall, PCSrc, JSrc, J_target_DE, JR_target_DE, Br_target_DE,
        input  inst_sram_rdata,
        output inst_sram_en, inst_sram_wen, inst_sram_addr,
        output Inst_IF_DE, PC_IF_DE, PC_add_4_IF_DE, Valid_IF_DE
    );

    modport slave (
        output IF_Stall, PCSrc, JSrc, J_target_DE, JR_target_DE, Br_target_DE,
        output inst_sram_rdata,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr,
        input  Inst_IF_DE, PC_IF_DE, PC_add_4_IF_DE, Valid_IF_DE
    );
endinterface

// File: rtl/fetch.sv
// ----------------------------------------------------------------------------
// fetch -- instruction fetch stage with a one-cycle-latency instruction SRAM.
//   clk    : sole clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : fetch_if.master (redirect inputs, SRAM request/response,
//            registered IF/DE outputs)
// r_pc is the address whose data is on inst_sram_rdata this cycle. The next
// request address is combinational so a DE redirect reaches the SRAM in the
// same cycle. Branches have a delay slot: the word at r_pc always enters IF/DE.
// ----------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic      clk,
    input  logic      resetn,
    fetch_if.master   bus
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [1:0]      SRC_BR   = 2'b01;
    localparam logic [1:0]      SRC_JMP  = 2'b10;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc_de;
    logic [XLEN-1:0] r_pc4_de;
    logic            r_valid;
    logic            r_en;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_req_addr;

    // Redirect select from DE; reserved encoding falls through to sequential.
    always_comb begin
        w_pc_plus4 = r_pc + PC_STEP;
        w_next_pc  = w_pc_plus4;
        case (bus.PCSrc)
            SRC_BR:  w_next_pc = bus.Br_target_DE;
            SRC_JMP: w_next_pc = bus.JSrc ? bus.JR_target_DE : bus.J_target_DE;
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    // Request address: a stall re-requests the word currently being returned.
    always_comb begin
        w_req_addr = RESET_PC;
        case (r_state)
            ST_RUN:  w_req_addr = bus.IF_Stall ? r_pc : w_next_pc;
            default: w_req_addr = RESET_PC;
        endcase
    end

    // Control FSM and IF/DE pipeline register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_RST;
            r_pc     <= RESET_PC - PC_STEP;
            r_inst   <= '0;
            r_pc_de  <= '0;
            r_pc4_de <= '0;
            r_valid  <= 1'b0;
            r_en     <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_state <= ST_BOOT;
                    r_en    <= 1'b1;
                end
                ST_BOOT: begin
                    // rdata is not meaningful yet: load a bubble.
                    r_state  <= ST_RUN;
                    r_en     <= 1'b1;
                    r_pc     <= RESET_PC;
                    r_inst   <= '0;
                    r_pc_de  <= '0;
                    r_pc4_de <= '0;
                    r_valid  <= 1'b0;
                end
                ST_RUN: begin
                    r_en <= 1'b1;
                    if (!bus.IF_Stall) begin
                        r_pc     <= w_next_pc;
                        r_inst   <= bus.inst_sram_rdata;
                        r_pc_de  <= r_pc;
                        r_pc4_de <= w_pc_plus4;
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: restart cleanly through BOOT.
                    r_state <= ST_BOOT;
                    r_en    <= 1'b1;
                    r_pc    <= RESET_PC - PC_STEP;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst_sram_en    = r_en;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = w_req_addr;
    assign bus.Inst_IF_DE      = r_inst;
    assign bus.PC_IF_DE        = r_pc_de;
    assign bus.PC_add_4_IF_DE  = r_pc4_de;
    assign bus.Valid_IF_DE     = r_valid;

endmodule
